demux_16_wr: RTL and testbench
==============================

// Module: demux_16_wr
// PURPOSE
//   Write side of the 16-entry, 32-bit word bank; the 16:1 read mux selects from this bank.
//   Accepts one write per cycle over a valid/ready handshake and decodes a 4-bit select into a one-hot write enable.
//   Stores the word into the addressed entry.
//   Also runs a sequenced bulk clear that zeroes one entry per cycle; outputs q0..q15 feed the read mux directly.
// PARAMETERS
//   WIDTH   32  data word width, in bits
//   SEL_W   4   select width; entry count is 1<<SEL_W = 16 (only 4 supported)
// PORTS
//   clock       in   1      single clock, all state updates on rising edge
//   reset       in   1      synchronous, active-high reset
//   wr_valid    in   1      write request present
//   wr_ready    out  1      bank can accept a write this cycle
//   wr_sel      in   4      destination entry index
//   wr_data     in   WIDTH  word to store
//   clr_req     in   1      request a bulk clear of all entries
//   busy        out  1      clear sequence in progress
//   we_onehot   out  16     registered one-hot of the entry committed last cycle
//   q0..q15     out  WIDTH  entry contents, registered
// BEHAVIOUR
//   Reset:
//     - Clock is 'clock'; reset is 'reset', synchronous and active-high.
//     - On reset: q0..q15=0, we_onehot=0, busy=0, state=IDLE, clear counter=0.
//     - wr_ready=0 while reset is high.
//   FSM states: IDLE, CLEAR.
//   IDLE:
//     - wr_ready = ~clr_req & ~reset (combinational).
//     - Accept = wr_valid & wr_ready. At the next edge: q[wr_sel] <= wr_data and we_onehot <= 1<<wr_sel.
//     - Write latency is 1 cycle; qN shows the new data the cycle after the handshake.
//     - If no write is accepted, we_onehot <= 0; it is a single-cycle pulse.
//     - clr_req=1 wins over a same-cycle write: the write is not accepted, the next state is CLEAR, and the counter is 0.
//   CLEAR:
//     - busy=1 and wr_ready=0.
//     - Each cycle: q[cnt] <= 0, cnt <= cnt+1, we_onehot=0.
//     - After the cycle with cnt=15, the counter wraps to 0 and the state returns to IDLE.
//     - The clear lasts exactly 16 cycles; busy falls on the edge after entry 15 is zeroed.
//     - clr_req during CLEAR is ignored and does not restart the count.
//     - Entries not yet cleared keep their old values until their cycle.
//   Reset during CLEAR aborts the sequence and all entries go to 0 at once.
//   Back-to-back writes to the same entry: the last accepted write wins, one per cycle, with no bubbles.
//   The upstream side must hold wr_sel and wr_data stable while wr_valid=1 and wr_ready=0.
// CONFIGURATION
//   DEMUX_ZERO_LOCK_EN defined:
//     - Entry 0 is hardwired to zero: q0 is constant 0.
//     - Writes with wr_sel=0 complete the handshake but are discarded.
//     - we_onehot[0] is never set, and CLEAR still takes 16 cycles.
//   DEMUX_ZERO_LOCK_EN not defined: entry 0 behaves like every other entry.
// STRUCTURE
//   Shared package: NUM_ENTRIES=16, SEL_W=4, state encoding (IDLE=1'b0, CLEAR=1'b1).
//   Sub-module decoder_4to16 (sel, en -> 16-bit one-hot).
//     - Used for both the write-enable path and the clear-counter path, selected by state.
// TESTING
//   - Reset: reset=1 for 2 cycles -> all q=0, we_onehot=0, busy=0, wr_ready=0; after release wr_ready=1.
//   - Write: valid, sel=5, data=32'hDEADBEEF -> next cycle q5=DEADBEEF, we_onehot=16'h0020, other q unchanged.
//   - Back-to-back: sel=3 data=1 then sel=3 data=2 -> q3=2 after 2 cycles, we_onehot=0x0008 for both cycles.
//   - Clear: fill all entries with 32'hA5A5_0000|i, pulse clr_req -> busy=1 for 16 cycles.
//     Entry i reads 0 from cycle i+1; wr_ready=0 throughout.
//   - Collision: clr_req=1 and wr_valid=1 in the same cycle -> write not accepted, CLEAR entered.
//     A write held through CLEAR is accepted in the first IDLE cycle.
//   - Mid-clear reset: reset at clear cycle 7 -> all q=0 next cycle, state IDLE, busy=0.
//   - With DEMUX_ZERO_LOCK_EN: write sel=0 data=7 -> handshake completes, q0 stays 0, we_onehot=0.

Source files
------------

// File: rtl/demux_16_wr_pkg.sv
// Shared constants and state encoding for the 16-entry word-bank write side.
package demux_16_wr_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned NUM_ENTRIES = 1 << SEL_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/demux_16_wr_decoder.sv
// 4-to-16 one-hot decoder with enable; shared by the write path and the clear sequencer.
module decoder_4to16
  import demux_16_wr_pkg::*;
(
  input  logic [SEL_W-1:0]       sel_i,
  input  logic                   en_i,
  output logic [NUM_ENTRIES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux_16_wr.sv
// Write side of the 16 x WIDTH word bank: handshake write plus sequenced bulk clear.
// Optional build macro DEMUX_ZERO_LOCK_EN hardwires entry 0 to zero.
module demux_16_wr
  import demux_16_wr_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_req,
  output logic                   busy,
  output logic [NUM_ENTRIES-1:0] we_onehot,
  output logic [WIDTH-1:0]       q0,
  output logic [WIDTH-1:0]       q1,
  output logic [WIDTH-1:0]       q2,
  output logic [WIDTH-1:0]       q3,
  output logic [WIDTH-1:0]       q4,
  output logic [WIDTH-1:0]       q5,
  output logic [WIDTH-1:0]       q6,
  output logic [WIDTH-1:0]       q7,
  output logic [WIDTH-1:0]       q8,
  output logic [WIDTH-1:0]       q9,
  output logic [WIDTH-1:0]       q10,
  output logic [WIDTH-1:0]       q11,
  output logic [WIDTH-1:0]       q12,
  output logic [WIDTH-1:0]       q13,
  output logic [WIDTH-1:0]       q14,
  output logic [WIDTH-1:0]       q15
);

  state_e                   state_q, state_d;
  logic [SEL_W-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]         bank_q [NUM_ENTRIES];
  logic [WIDTH-1:0]         bank_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   we_q, we_d;
  logic                     busy_q, busy_d;

  logic                     clearing_c;
  logic                     accept_c;
  logic [SEL_W-1:0]         dec_sel_c;
  logic                     dec_en_c;
  logic [NUM_ENTRIES-1:0]   dec_onehot_c;
  logic [NUM_ENTRIES-1:0]   commit_c;

  assign clearing_c = (state_q == CLEAR);
  assign wr_ready   = (state_q == IDLE) & ~clr_req & ~reset;
  assign accept_c   = wr_valid & wr_ready;

  // One decoder serves both paths: the clear counter owns it while clearing.
  assign dec_sel_c = clearing_c ? cnt_q : wr_sel;
  assign dec_en_c  = clearing_c | accept_c;

  decoder_4to16 u_dec (
    .sel_i    (dec_sel_c),
    .en_i     (dec_en_c),
    .onehot_o (dec_onehot_c)
  );

`ifdef DEMUX_ZERO_LOCK_EN
  assign commit_c = dec_onehot_c & ~NUM_ENTRIES'(1);
`else
  assign commit_c = dec_onehot_c;
`endif

  // Next-state, bank update and write-enable pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    we_d    = '0;

    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (commit_c[i]) bank_d[i] = clearing_c ? '0 : wr_data;
    end

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (accept_c) begin
          we_d = commit_c;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + SEL_W'(1);
        if (cnt_q == SEL_W'(NUM_ENTRIES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef DEMUX_ZERO_LOCK_EN
    bank_d[0] = '0;
`endif

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= '0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
    end
  end

  assign busy      = busy_q;
  assign we_onehot = we_q;

  assign q0  = bank_q[0];
  assign q1  = bank_q[1];
  assign q2  = bank_q[2];
  assign q3  = bank_q[3];
  assign q4  = bank_q[4];
  assign q5  = bank_q[5];
  assign q6  = bank_q[6];
  assign q7  = bank_q[7];
  assign q8  = bank_q[8];
  assign q9  = bank_q[9];
  assign q10 = bank_q[10];
  assign q11 = bank_q[11];
  assign q12 = bank_q[12];
  assign q13 = bank_q[13];
  assign q14 = bank_q[14];
  assign q15 = bank_q[15];

endmodule

// File: tb/tb_demux_16_wr.sv
// Scoreboard bench for demux_16_wr: directed scenarios then randomized traffic against a bank model.
module tb_demux_16_wr;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        busy;
  logic [15:0] we_onehot;
  logic [31:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12, q13, q14, q15;

  demux_16_wr dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .clr_req(clr_req), .busy(busy),
    .we_onehot(we_onehot),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .q8(q8), .q9(q9), .q10(q10), .q11(q11), .q12(q12), .q13(q13), .q14(q14), .q15(q15)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0]       we;
    logic              busy;
    logic [15:0][31:0] bank;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DEMUX_ZERO_LOCK_EN
  localparam bit ZL = 1'b1;
`else
  localparam bit ZL = 1'b0;
`endif

  // Reference model: bank contents and number of clear cycles still to run
  logic [31:0] m [16];
  int          clr_left = 0;
  logic        last_rdy = 1'b0;

  logic [15:0][31:0] dut_bank;
  assign dut_bank = {q15, q14, q13, q12, q11, q10, q9, q8, q7, q6, q5, q4, q3, q2, q1, q0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic [3:0] s,
                     input logic [31:0] d, input logic c);
    exp_t        e;
    logic [15:0] we;
    logic        exp_rdy;
    @(negedge clock);
    reset = rst; wr_valid = v; wr_sel = s; wr_data = d; clr_req = c;
    exp_rdy = !rst && (clr_left == 0) && !c;
    #1 check("wr_ready", 64'(wr_ready), 64'(exp_rdy));
    last_rdy = exp_rdy;
    we = '0;
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      m[16 - clr_left] = '0;
      clr_left--;
    end else if (c) begin
      clr_left = 16;
    end else if (v) begin
      if (!(ZL && s == 4'd0)) begin
        m[s] = d;
        we   = 16'(1) << s;
      end
    end
    e.we   = we;
    e.busy = (clr_left > 0);
    for (int i = 0; i < 16; i++) e.bank[i] = m[i];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 4'(i), 32'hA5A5_0000 | 32'(i), 1'b0);
  endtask

  // Monitor: one expected snapshot per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("we_onehot", 64'(we_onehot), 64'(e.we));
        check("busy", 64'(busy), 64'(e.busy));
        for (int i = 0; i < 16; i++)
          check($sformatf("q%0d", i), 64'(dut_bank[i]), 64'(e.bank[i]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    logic        v, c, rst, hold;
    logic [3:0]  s;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) m[i] = '0;
    reset = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_req = 1'b0;

    cyc(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b0, 1'b1, 4'd3, 32'd1, 1'b0);
    cyc(1'b0, 1'b1, 4'd3, 32'd2, 1'b0);
    cyc(1'b0, 1'b1, 4'd0, 32'd7, 1'b0);
    idle(1);

    // Full-bank clear
    fill();
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    idle(18);

    // Collision: write held through the whole clear
    fill();
    cyc(1'b0, 1'b1, 4'd9, 32'h1234_5678, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 4'd9, 32'h1234_5678, 1'b1 & (i == 4));
    idle(2);

    // Reset in the middle of a clear
    fill();
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    idle(7);
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    idle(2);

    // Randomized traffic honouring the hold-while-stalled rule
    hold = 1'b0; v = 1'b0; s = '0; d = '0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom % 64) == 0;
      c   = ($urandom % 16) == 0;
      if (!hold) begin
        v = ($urandom % 4) != 0;
        s = 4'($urandom);
        d = $urandom;
      end
      cyc(rst, v, s, d, c);
      hold = v && !last_rdy;
    end
    idle(2);

    @(posedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
